// File: rtl/main_pkg.sv
// Shared types and sizes for the fixed-point divider.
// The numerator is the dividend with FRAC zero bits appended.
package main_pkg;

   localparam int WIDTH = 10;
   localparam int FRAC  = 4;
   localparam int NUM_W = WIDTH + FRAC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/main_datapath.sv
// Restoring shift-subtract datapath: operand, remainder and quotient registers plus step counter.
// quo_next is the quotient after the current step, so the FSM can capture the final result on the last step.
module main_datapath #(
   parameter int WIDTH = 10,
   parameter int FRAC  = 4
) (
   input  logic                   clk,
   input  logic                   sclr,
   input  logic                   load,
   input  logic                   step,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   output logic [WIDTH+FRAC-1:0]  quo_next,
   output logic                   last
);

   localparam int QW    = WIDTH + FRAC;
   localparam int CNT_W = $clog2(QW);

   logic [QW-1:0]    num_q;
   logic [QW-1:0]    quo_q;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] rem_nx;

   // The remainder is always below the divisor, so the borrow bit of the
   // trial subtraction alone tells whether the divisor fits.
   always_comb begin
      rem_sh   = {rem_q, num_q[QW-1]};
      diff     = rem_sh - {1'b0, div_q};
      fits     = ~diff[WIDTH];
      rem_nx   = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_next = {quo_q[QW-2:0], fits};
      last     = (cnt_q == CNT_W'(QW - 1));
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         num_q <= '0;
         quo_q <= '0;
         div_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         num_q <= {a, {FRAC{1'b0}}};
         quo_q <= '0;
         div_q <= b;
         rem_q <= '0;
         cnt_q <= '0;
      end else if (step) begin
         num_q <= {num_q[QW-2:0], 1'b0};
         quo_q <= quo_next;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/main.sv
// Unsigned fixed-point divider: q = floor(a * 2^FRAC / b), saturating on overflow.
//   state | meaning
//   IDLE  | no result yet, waiting for start
//   CALC  | one shift-subtract step per cycle, busy=1
//   DONE  | result (or divide-by-zero) held, valid=1, start relaunches
module main #(
   parameter int WIDTH = main_pkg::WIDTH,
   parameter int FRAC  = main_pkg::FRAC
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             start,
   input  logic             clk,
   input  logic             sclr,
   output logic             dvz,
   output logic             ovf,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] q_out
);

   import main_pkg::*;

   localparam int QW = WIDTH + FRAC;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_d;
   logic             dvz_d, ovf_d, busy_d, valid_d;
   logic             load, step, last;
   logic [QW-1:0]    quo_next;

   main_datapath #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dp (
      .clk      (clk),
      .sclr     (sclr),
      .load     (load),
      .step     (step),
      .a        (a_in),
      .b        (b_in),
      .quo_next (quo_next),
      .last     (last)
   );

   always_comb begin
      state_d = state_q;
      q_d     = q_out;
      dvz_d   = dvz;
      ovf_d   = ovf;
      busy_d  = busy;
      valid_d = valid;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               valid_d = 1'b0;
               dvz_d   = 1'b0;
               ovf_d   = 1'b0;
               if (b_in == '0) begin
                  state_d = DONE;
                  dvz_d   = 1'b1;
                  valid_d = 1'b1;
                  q_d     = '0;
               end else begin
                  state_d = CALC;
                  busy_d  = 1'b1;
                  load    = 1'b1;
               end
            end
         end
         CALC: begin
            step = 1'b1;
            if (last) begin
               state_d = DONE;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               if (|quo_next[QW-1:WIDTH]) begin
                  ovf_d = 1'b1;
                  q_d   = '1;
               end else begin
                  ovf_d = 1'b0;
                  q_d   = quo_next[WIDTH-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= IDLE;
         q_out   <= '0;
         dvz     <= 1'b0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         valid   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_out   <= q_d;
         dvz     <= dvz_d;
         ovf     <= ovf_d;
         busy    <= busy_d;
         valid   <= valid_d;
      end
   end

endmodule

// File: tb/tb_main.sv
// Directed-vector bench for the fixed-point divider; expected quotients are hand-computed.
module tb_main;

   logic [9:0] a_in, b_in;
   logic       start, clk, sclr;
   logic       dvz, ovf, busy, valid;
   logic [9:0] q_out;

   int vectors = 0;
   int errors  = 0;

   main dut (
      .a_in  (a_in),
      .b_in  (b_in),
      .start (start),
      .clk   (clk),
      .sclr  (sclr),
      .dvz   (dvz),
      .ovf   (ovf),
      .busy  (busy),
      .valid (valid),
      .q_out (q_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sclr = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
      tick();
      sclr = 1'b0;
      vectors++;
      if ({q_out, dvz, ovf, busy, valid} !== 14'd0) begin
         errors++;
         $display("FAIL reset: outputs=%h required=0", {q_out, dvz, ovf, busy, valid});
      end
   endtask

   // Launch one division, scramble the operands during CALC, check latency and result.
   task automatic test_division(input logic [9:0] a, input logic [9:0] b,
                                input logic [9:0] exp_q, input logic exp_ovf,
                                input string name);
      int n;
      a_in = a; b_in = b; start = 1'b1;
      tick();
      start = 1'b0;
      a_in = ~a; b_in = 10'd1;
      vectors++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b valid=%b required busy=1 valid=0", name, busy, valid);
      end
      n = 0;
      while (!valid && n < 40) begin
         if (n == 6) start = 1'b1;
         if (n == 8) start = 1'b0;
         tick();
         n++;
      end
      vectors++;
      if (n != 14) begin
         errors++;
         $display("FAIL %s latency: cycles=%0d required=14", name, n);
      end
      vectors++;
      if (q_out !== exp_q || ovf !== exp_ovf || dvz !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s result: q=%h ovf=%b dvz=%b busy=%b required q=%h ovf=%b dvz=0 busy=0",
                  name, q_out, ovf, dvz, busy, exp_q, exp_ovf);
      end
      tick(); tick();
      vectors++;
      if (q_out !== exp_q || valid !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s hold: q=%h valid=%b busy=%b required q=%h valid=1 busy=0",
                  name, q_out, valid, busy, exp_q);
      end
   endtask

   task automatic test_dvz();
      bit saw_busy;
      a_in = 10'h155; b_in = '0; start = 1'b1;
      tick();
      start = 1'b0;
      saw_busy = busy;
      vectors++;
      if (valid !== 1'b1 || dvz !== 1'b1 || q_out !== 10'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL dvz result: valid=%b dvz=%b q=%h ovf=%b required 1 1 000 0", valid, dvz, q_out, ovf);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         saw_busy |= busy;
      end
      vectors++;
      if (saw_busy || valid !== 1'b1 || dvz !== 1'b1) begin
         errors++;
         $display("FAIL dvz hold: busy_seen=%b valid=%b dvz=%b required 0 1 1", saw_busy, valid, dvz);
      end
   endtask

   task automatic test_abort();
      bit saw_valid;
      a_in = 10'd520; b_in = 10'd116; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      vectors++;
      if ({q_out, dvz, ovf, busy, valid} !== 14'd0) begin
         errors++;
         $display("FAIL abort: outputs=%h required=0", {q_out, dvz, ovf, busy, valid});
      end
      saw_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         saw_valid |= valid | busy;
      end
      vectors++;
      if (saw_valid) begin
         errors++;
         $display("FAIL abort idle: valid/busy seen=1 required=0");
      end
      test_division(10'd16, 10'd8, 10'd32, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      int n;
      a_in = 10'd520; b_in = 10'd116; start = 1'b1;
      tick();
      a_in = 10'd256; b_in = 10'd8;
      n = 0;
      while (!valid && n < 40) begin tick(); n++; end
      vectors++;
      if (n != 14 || q_out !== 10'd71 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b first: cycles=%0d q=%h ovf=%b required 14 047 0", n, q_out, ovf);
      end
      tick();
      vectors++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b relaunch: busy=%b valid=%b required busy=1 valid=0", busy, valid);
      end
      start = 1'b0;
      a_in = 10'd3; b_in = 10'd1000;
      n = 0;
      while (!valid && n < 40) begin tick(); n++; end
      vectors++;
      if (n != 14 || q_out !== 10'd512 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b second: cycles=%0d q=%h ovf=%b required 14 200 0", n, q_out, ovf);
      end
   endtask

   always @(negedge clk) begin
      if (busy === 1'b1 && valid === 1'b1) begin
         errors++;
         $display("FAIL busy_valid_exclusive: busy=1 valid=1 required not both");
      end
   end

   initial begin
      test_reset();
      test_division(10'b1000001000, 10'b0001110100, 10'b0001000111, 1'b0, "q6_4_basic");
      test_division(10'b1111110000, 10'b0000001100, 10'h3FF, 1'b1, "overflow");
      test_division(10'd16, 10'd8, 10'd32, 1'b0, "exact");
      test_division(10'd1023, 10'd1023, 10'd16, 1'b0, "max_by_max");
      test_division(10'd1, 10'd1023, 10'd0, 1'b0, "underflow_zero");
      test_division(10'd64, 10'd1, 10'd1023, 1'b1, "ovf_edge");
      test_division(10'd63, 10'd1, 10'd1008, 1'b0, "no_ovf_edge");
      test_dvz();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
